// File: rtl/free_list.sv
// Circular free list of physical register tags: one pop, up to two pushes per cycle.
// Optional macro FREELIST_BYPASS_EN forwards a retiring tag straight to PR_new when the list is empty.
module free_list #(
    parameter int PR_W       = 6,
    parameter int DEPTH      = 32,
    parameter int FIRST_FREE = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            get_free,
    input  logic            hazard_stall,
    output logic [PR_W-1:0] PR_new,
    output logic            empty,
    output logic [PR_W-1:0] free_cnt,
    input  logic            retire_reg,
    input  logic            RegDest_retire,
    input  logic [PR_W-1:0] PR_old_RT,
    input  logic            recover,
    input  logic            RegDest_out,
    input  logic [PR_W-1:0] PR_new_flush,
    output logic            err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [PR_W:0] CNT_MAX = (PR_W+1)'(DEPTH);
    localparam logic [PR_W:0] ONE     = (PR_W+1)'(1);
    localparam logic [PR_W:0] TWO     = (PR_W+1)'(2);

    logic [PR_W-1:0] mem [DEPTH];
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [PR_W-1:0] count;
    logic            err_q;

    logic            push_rt;
    logic            push_fl;
    logic            push_rt_mem;
    logic            pop_mem;
    logic            byp_sel;
    logic            byp_pop;
    logic [PR_W:0]   space;
    logic            acc_rt;
    logic            acc_fl;
    logic            overflow;
    logic [AW-1:0]   fl_idx;

    always_comb begin
        push_rt = retire_reg & RegDest_retire;
        push_fl = recover & RegDest_out;
`ifdef FREELIST_BYPASS_EN
        byp_sel = (count == '0) & push_rt;
        byp_pop = byp_sel & get_free & ~hazard_stall;
`else
        byp_sel = 1'b0;
        byp_pop = 1'b0;
`endif
        // A bypassed retire tag is consumed directly and never enters the array.
        push_rt_mem = push_rt & ~byp_pop;
        pop_mem     = get_free & ~hazard_stall & (count != '0);

        space  = CNT_MAX - {1'b0, count} + {{PR_W{1'b0}}, pop_mem};
        acc_rt = push_rt_mem & (space >= ONE);
        // The rollback push is the first one dropped when room is short.
        acc_fl = push_fl & (space >= (acc_rt ? TWO : ONE));
        overflow = (push_rt_mem & ~acc_rt) | (push_fl & ~acc_fl);
        fl_idx   = tail + AW'(acc_rt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= PR_W'(FIRST_FREE + i);
            end
            head  <= '0;
            tail  <= '0;
            count <= PR_W'(DEPTH);
            err_q <= 1'b0;
        end else begin
            if (acc_rt) begin
                mem[tail] <= PR_old_RT;
            end
            if (acc_fl) begin
                mem[fl_idx] <= PR_new_flush;
            end
            head  <= head + AW'(pop_mem);
            tail  <= tail + AW'(acc_rt) + AW'(acc_fl);
            count <= count - PR_W'(pop_mem) + PR_W'(acc_rt) + PR_W'(acc_fl);
            err_q <= err_q | overflow;
        end
    end

    assign PR_new   = byp_sel ? PR_old_RT : mem[head];
    assign empty    = (count == '0);
    assign free_cnt = count;
    assign err      = err_q;

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: reset, pops, pushes, stall, overflow and drop order.
module tb_free_list;
    localparam int PR_W = 6;

    logic            clk = 1'b0;
    logic            rst;
    logic            get_free;
    logic            hazard_stall;
    logic [PR_W-1:0] PR_new;
    logic            empty;
    logic [PR_W-1:0] free_cnt;
    logic            retire_reg;
    logic            RegDest_retire;
    logic [PR_W-1:0] PR_old_RT;
    logic            recover;
    logic            RegDest_out;
    logic [PR_W-1:0] PR_new_flush;
    logic            err;

    int n_cmp = 0;
    int n_err = 0;

    free_list #(.PR_W(PR_W), .DEPTH(32), .FIRST_FREE(32)) dut (
        .clk(clk), .rst(rst), .get_free(get_free), .hazard_stall(hazard_stall),
        .PR_new(PR_new), .empty(empty), .free_cnt(free_cnt),
        .retire_reg(retire_reg), .RegDest_retire(RegDest_retire), .PR_old_RT(PR_old_RT),
        .recover(recover), .RegDest_out(RegDest_out), .PR_new_flush(PR_new_flush),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        get_free = 0; hazard_stall = 0;
        retire_reg = 0; RegDest_retire = 0; PR_old_RT = '0;
        recover = 0; RegDest_out = 0; PR_new_flush = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic push_rt(input logic [PR_W-1:0] tag);
        retire_reg = 1; RegDest_retire = 1; PR_old_RT = tag;
        tick();
        retire_reg = 0; RegDest_retire = 0;
    endtask

    initial begin
        rst = 0;
        do_reset();
        chk("rst_pr_new", PR_new, 32'h20);
        chk("rst_empty", empty, 0);
        chk("rst_cnt", free_cnt, 32);
        chk("rst_err", err, 0);

        // Three consecutive pops
        get_free = 1;
        chk("pop0", PR_new, 32'h20); tick();
        chk("pop1", PR_new, 32'h21); tick();
        chk("pop2", PR_new, 32'h22); tick();
        chk("pop3_cnt", free_cnt, 29);
        chk("pop3_empty", empty, 0);

        // Drain the rest
        for (int i = 0; i < 29; i++) begin
            chk("drain", PR_new, 32'h23 + i);
            tick();
        end
        chk("drain_empty", empty, 1);
        chk("drain_cnt", free_cnt, 0);
        tick();
        chk("underflow_cnt", free_cnt, 0);
        chk("underflow_empty", empty, 1);
        chk("underflow_err", err, 0);
        get_free = 0;

        // Refill one from empty, then pop it
        push_rt(6'h05);
        chk("refill_cnt", free_cnt, 1);
        chk("refill_tag", PR_new, 32'h05);
        chk("refill_empty", empty, 0);
        get_free = 1; tick(); get_free = 0;
        chk("refill_pop_empty", empty, 1);

        // Build count=10, then same-cycle pop plus two pushes
        for (int i = 0; i < 10; i++) push_rt(6'h10 + 6'(i));
        chk("ten_cnt", free_cnt, 10);
        get_free = 1;
        retire_reg = 1; RegDest_retire = 1; PR_old_RT = 6'h07;
        recover = 1; RegDest_out = 1; PR_new_flush = 6'h27;
        chk("mix_head", PR_new, 32'h10);
        tick();
        idle();
        chk("mix_cnt", free_cnt, 11);
        get_free = 1;
        for (int i = 0; i < 9; i++) begin
            chk("mix_old", PR_new, 32'h11 + i);
            tick();
        end
        chk("mix_rt_tag", PR_new, 32'h07); tick();
        chk("mix_fl_tag", PR_new, 32'h27); tick();
        get_free = 0;
        chk("mix_empty", empty, 1);

        // Stall holds the head
        push_rt(6'h30);
        push_rt(6'h31);
        get_free = 1; hazard_stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_tag", PR_new, 32'h30);
            chk("stall_cnt", free_cnt, 2);
        end
        idle();

        // Full list: pop plus push is not an overflow
        do_reset();
        get_free = 1;
        retire_reg = 1; RegDest_retire = 1; PR_old_RT = 6'h03;
        tick();
        idle();
        chk("full_swap_cnt", free_cnt, 32);
        chk("full_swap_err", err, 0);
        chk("full_swap_tag", PR_new, 32'h21);

        // Full list: plain push overflows
        push_rt(6'h03);
        chk("ovf_err", err, 1);
        chk("ovf_cnt", free_cnt, 32);
        chk("ovf_tag", PR_new, 32'h21);
        do_reset();
        chk("ovf_rst_err", err, 0);
        chk("ovf_rst_tag", PR_new, 32'h20);
        chk("ovf_rst_cnt", free_cnt, 32);

        // One slot free, two pushes: rollback tag is dropped
        get_free = 1; tick(); get_free = 0;
        retire_reg = 1; RegDest_retire = 1; PR_old_RT = 6'h0A;
        recover = 1; RegDest_out = 1; PR_new_flush = 6'h0B;
        tick();
        idle();
        chk("drop_err", err, 1);
        chk("drop_cnt", free_cnt, 32);
        get_free = 1;
        for (int i = 0; i < 31; i++) tick();
        get_free = 0;
        chk("drop_kept_tag", PR_new, 32'h0A);
        chk("drop_kept_cnt", free_cnt, 1);
        chk("drop_err_sticky", err, 1);

        do_reset();
        chk("final_err", err, 0);
        chk("final_tag", PR_new, 32'h20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/free_list.md
Name: free_list

Overview:
- Circular FIFO of free physical register tags for the OoO pipe. It sits directly upstream of the reorder buffer.
- Supplies the new PR tag that the rename/dispatch stage sends to the ROB as PR_new_DP.
- Takes back tags released by the ROB on two paths:
  - Retire path: PR_old_RT, qualified by retire_reg and RegDest_retire.
  - Rollback path: PR_new_flush, qualified by recover and RegDest_out.
- Accepts one pop and up to two pushes per cycle.

Parameters:
- PR_W, 6, physical register tag width.
- DEPTH, 32, number of entries; equals physical regs minus architectural regs.
- FIRST_FREE, 32, first tag placed in the list at reset; entry i resets to FIRST_FREE+i.

Ports:
- clk  input  1  pipeline clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- get_free  input  1  dispatch wants a new PR (isDispatch & RegDest)
- hazard_stall  input  1  dispatch stalled; suppresses the pop
- PR_new  output  PR_W  tag at head; valid when !empty
- empty  output  1  count==0
- free_cnt  output  PR_W  number of free tags, 0..DEPTH
- retire_reg  input  1  ROB retiring an instruction this cycle
- RegDest_retire  input  1  retiring instruction wrote a register
- PR_old_RT  input  PR_W  stale tag released at retire
- recover  input  1  ROB rolling back one entry this cycle
- RegDest_out  input  1  rolled-back entry had a register destination
- PR_new_flush  input  PR_W  speculative tag returned on rollback
- err  output  1  sticky overflow flag

Behaviour:
- State: mem[DEPTH], head and tail pointers (log2 DEPTH bits, natural wrap), count (PR_W bits).
- Reset (rst=1 at posedge, also mid-operation): mem[i]=FIRST_FREE+i, head=0, tail=0, count=DEPTH, err=0. Pending pops and pushes that cycle are discarded.
- Outputs after reset: PR_new=FIRST_FREE, empty=0, free_cnt=DEPTH, err=0.
- PR_new = mem[head], combinational; zero-latency read. empty and free_cnt are combinational from count.
- pop = get_free & !hazard_stall & !empty. On pop, head advances by 1 at posedge. The consumer samples PR_new in the same cycle.
- Pop requested while empty: no state change, and err is not set. Dispatch must stall on empty.
- push_rt = retire_reg & RegDest_retire.
- push_fl = recover & RegDest_out.
- Write order:
  - push_rt writes mem[tail].
  - push_fl writes mem[tail+1] if push_rt is also active, else mem[tail].
  - tail advances by push_rt+push_fl.
- count_next = count - pop + push_rt + push_fl.
- Same-cycle pop and push on a non-empty list: both take effect. PR_new in that cycle is the old head value.
- Overflow: if count - pop + pushes > DEPTH, err sets (sticky until rst).
  - Excess pushes are dropped, push_fl first, then push_rt.
  - count saturates at DEPTH.
- Wrap-around: pointers wrap modulo DEPTH with no special handling.
- No tag value checking: a duplicate tag is the caller's error.

Optional Feature:
- Macro FREELIST_BYPASS_EN.
- Defined:
  - When empty=1 and push_rt=1, PR_new = PR_old_RT and the pop is allowed (get_free & !hazard_stall).
  - The bypassed tag is not written to mem and tail does not advance for it.
  - push_fl in that cycle is written normally.
  - empty output stays 1 in the bypass cycle.
- Not defined: empty blocks the pop unconditionally; PR_new = mem[head].

Test Plan:
- Reset, then get_free=1 for 3 cycles -> PR_new 0x20, 0x21, 0x22 on successive cycles; free_cnt 32->29; empty=0.
- Pop all 32 tags -> empty=1, free_cnt=0. One more get_free -> no change, err=0.
- From empty: retire_reg=1, RegDest_retire=1, PR_old_RT=0x05 -> next cycle free_cnt=1, PR_new=0x05. Pop it -> empty=1.
- Same cycle: pop, plus retire of 0x07 and recover of 0x27, with count=10 -> count=11. The next two entries after existing ones are 0x07 then 0x27.
- hazard_stall=1 with get_free=1 for 3 cycles -> PR_new and free_cnt unchanged.
- Full list (count=32), retire push of 0x03 -> err=1, free_cnt=32. Assert rst -> err=0, PR_new=0x20.
